// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned       XLEN         = 32;
    localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0]   NOP          = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/m_inst_queue.sv
// QDEPTH-entry FIFO of {pc, inst} with a synchronous clear that wins over push/pop.
module m_inst_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      QDEPTH   = 2,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF,
    localparam int unsigned     AW       = $clog2(QDEPTH),
    localparam int unsigned     CW       = $clog2(QDEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t   mem_q [QDEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage is reset too so the head reads {RESET_PC, 0} straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '{pc: RESET_PC, inst: '0};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (!clear_i && push_i) mem_q[wr_ptr_q] <= push_entry_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/m_fetch.sv
// Instruction-fetch stage: PC, imem issue, response queue and redirect flush.
// Optional FETCH_PERF_EN adds delivered/flushed instruction counters.
module m_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     QDEPTH   = 2,
    parameter int unsigned     IMEM_AW  = 6
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic               w_redirect,
    input  logic [XLEN-1:0]    w_redirect_pc,
    output logic               w_imem_req,
    output logic [IMEM_AW-1:0] w_imem_addr,
    input  logic [XLEN-1:0]    w_imem_data,
    output logic               w_inst_valid,
    input  logic               w_inst_ready,
    output logic [XLEN-1:0]    w_inst,
    output logic [XLEN-1:0]    w_inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0]    w_fetch_cnt,
    output logic [XLEN-1:0]    w_flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned OW = $clog2(QDEPTH) + 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic            pop, push, q_full, q_empty;
    logic [CW-1:0]   q_count;
    logic [OW-1:0]   occ_after_pop;
    fetch_entry_t    push_entry, head;
    logic            unused_bits;

    assign unused_bits   = ^{w_redirect_pc[1:0], q_full};

    assign w_inst_valid  = !q_empty;
    assign pop           = w_inst_valid & w_inst_ready;
    assign occ_after_pop = OW'(q_count) + OW'(inflight_q) - OW'(pop);
    assign w_imem_req    = !w_rst && !w_redirect && (occ_after_pop < OW'(QDEPTH));
    assign w_imem_addr   = pc_q[IMEM_AW+1:2];

    // A redirect drops the response arriving this cycle; it belongs to the old path.
    assign push          = inflight_q & !w_redirect;
    assign push_entry    = '{pc: inflight_pc_q, inst: w_imem_data};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = w_imem_req;
        inflight_pc_d = inflight_pc_q;
        if (w_redirect) begin
            pc_d = {w_redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_imem_req) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    m_inst_queue #(
        .QDEPTH   (QDEPTH),
        .RESET_PC (RESET_PC)
    ) u_queue (
        .clk_i        (w_clk),
        .rst_i        (w_rst),
        .clear_i      (w_redirect),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (q_count),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    assign w_inst    = head.inst;
    assign w_inst_pc = head.pc;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (w_redirect) begin
                flush_cnt_q <= flush_cnt_q + 32'(q_count) + 32'(inflight_q) - 32'(pop);
            end
        end
    end

    assign w_fetch_cnt = fetch_cnt_q;
    assign w_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_m_fetch.sv
// Self-checking bench for m_fetch: directed scenarios plus random redirect/backpressure.
module tb_m_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned QDEPTH   = 2;
    localparam int unsigned IMEM_AW  = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst;
    logic [31:0]        inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]        fetch_cnt;
    logic [31:0]        flush_cnt;
`endif

    m_fetch #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH),
        .IMEM_AW  (IMEM_AW)
    ) dut (
        .w_clk         (clk),
        .w_rst         (rst),
        .w_redirect    (redirect),
        .w_redirect_pc (redirect_pc),
        .w_imem_req    (imem_req),
        .w_imem_addr   (imem_addr),
        .w_imem_data   (imem_data),
        .w_inst_valid  (inst_valid),
        .w_inst_ready  (inst_ready),
        .w_inst        (inst),
        .w_inst_pc     (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .w_fetch_cnt   (fetch_cnt),
        .w_flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [2**IMEM_AW];

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_data <= mem[imem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: delivered-order queue plus one pending fetch.
    fetch_entry_t exp_q [$];
    logic [31:0]  m_pc;
    bit           m_infl;
    logic [31:0]  m_ipc;
    logic [31:0]  m_fetch;
    logic [31:0]  m_flush;

    task automatic model_reset();
        exp_q.delete();
        m_pc    = RESET_PC;
        m_infl  = 1'b0;
        m_ipc   = RESET_PC;
        m_fetch = '0;
        m_flush = '0;
    endtask

    // Called at a negedge; drives one cycle, checks, advances the model, returns at next negedge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit           exp_valid, exp_pop, exp_req;
        int           occ;
        fetch_entry_t e;
        logic [31:0]  idx;
        redirect    = redir;
        redirect_pc = rpc;
        inst_ready  = rdy;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_pop   = exp_valid && rdy;
        occ       = exp_q.size() + int'(m_infl) - int'(exp_pop);
        exp_req   = !redir && (occ < int'(QDEPTH));
        check_eq("valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("inst", inst, exp_q[0].inst);
            check_eq("inst_pc", inst_pc, exp_q[0].pc);
        end
        check_eq("req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_eq("addr", 32'(imem_addr), (m_pc >> 2) & ((32'd1 << IMEM_AW) - 1));
        check_eq("push_when_full", 32'(dut.u_queue.push_i & dut.u_queue.full_o), 32'd0);
`ifdef FETCH_PERF_EN
        check_eq("fetch_cnt", fetch_cnt, m_fetch);
        check_eq("flush_cnt", flush_cnt, m_flush);
`endif
        if (exp_pop) begin
            void'(exp_q.pop_front());
            m_fetch = m_fetch + 1;
        end
        if (redir) begin
            m_flush = m_flush + exp_q.size() + int'(m_infl);
            exp_q.delete();
            m_infl = 1'b0;
            m_pc   = rpc & 32'hFFFF_FFFC;
        end else begin
            if (m_infl) begin
                idx    = (m_ipc >> 2) % (2**IMEM_AW);
                e.pc   = m_ipc;
                e.inst = mem[idx];
                exp_q.push_back(e);
            end
            if (exp_req) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 4;
            end
            m_infl = exp_req;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] tgt;
            tgt = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FF00 | tgt;
            step($urandom_range(0, 11) == 0, tgt, $urandom_range(0, 3) != 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
        check_eq({tag, "_inst"}, inst, 32'd0);
        check_eq({tag, "_pc"}, inst_pc, RESET_PC);
`ifdef FETCH_PERF_EN
        check_eq({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
        check_eq({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
    endtask

    initial begin
        for (int k = 0; k < 2**IMEM_AW; k++) mem[k] = ($urandom() << 8) | 32'(k + 1);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        imem_data   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Streaming, then backpressure and recovery.
        run(3, 1'b1);
        run(4, 1'b0);
        run(6, 1'b1);

        // Fill the queue, redirect while full, watch the target stream in.
        run(3, 1'b0);
        step(1'b1, 32'h0000_0040, 1'b0);
        run(6, 1'b1);

        // Redirect that coincides with a pop; low target bits must be dropped.
        run(2, 1'b1);
        step(1'b1, 32'h0000_0043, 1'b1);
        run(5, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        run(7, 1'b1);

        // Back-to-back redirects.
        step(1'b1, 32'h0000_0100, 1'b1);
        step(1'b1, 32'h0000_0020, 1'b1);
        run(5, 1'b1);

        run_random(400);

        // Async reset between edges while the stream is busy.
        run(3, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst = 1'b0;
        run(6, 1'b1);

        run_random(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
